// File: rtl/key_event_pkg.sv
// Shared types for the key event queue: event kinds, debounce FSM states and a sizing helper.
package key_event_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_REPEAT  = 2'd1,
        EVT_RELEASE = 2'd2
    } evt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_HELD     = 2'd2,
        ST_DB_REL   = 2'd3
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Registered first-word-fall-through FIFO with occupancy, empty flag and a strobe for
// pushes refused because the queue is full and nothing leaves in the same cycle.
module key_event_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     empty_o,
    output logic                     drop_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     rd_ptr_d;
    logic [AW:0]       level_q;
    logic [AW:0]       level_d;
    logic              full_s;
    logic              pop_do_s;
    logic              push_do_s;

    assign empty_o     = (level_q == {(AW + 1){1'b0}});
    assign full_s      = (level_q == LVL_FULL);
    assign level_o     = level_q;
    assign head_data_o = mem_q[rd_ptr_q];

    // Pop needs an entry present; a full queue still accepts a push when the head leaves.
    always_comb begin
        pop_do_s  = pop_i & ~empty_o;
        push_do_s = push_i & (~full_s | pop_do_s);
        drop_o    = push_i & full_s & ~pop_do_s;
        if (push_do_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_do_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_do_s, pop_do_s})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are only observed through level-qualified reads.
    always_ff @(posedge clk) begin
        if (push_do_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Debounces the scanner's key code into PRESS / REPEAT / RELEASE events and buffers them
// in a small FWFT queue so a slow consumer does not lose keystrokes.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int unsigned CODE_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 24000000,
    parameter int unsigned REPEAT_PERIOD   = 6000000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned REL_EVT_EN      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [CODE_W-1:0]             key_code,
    input  logic                          repeat_en,
    input  logic                          evt_ready,
    output logic                          evt_valid,
    output logic [1:0]                    evt_type,
    output logic [CODE_W-1:0]             evt_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          busy
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RPT_MAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned RPT_W   = $clog2(RPT_MAX) + 1;
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] DB_LAST         = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic             REL_PUSH        = (REL_EVT_EN != 0);

    typedef struct packed {
        evt_type_t         etype;
        logic [CODE_W-1:0] code;
    } key_evt_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [RPT_W-1:0]  rpt_q;
    logic [RPT_W-1:0]  rpt_d;
    logic [RPT_W-1:0]  rpt_target_s;
    logic              rpt_first_q;
    logic              rpt_first_d;
    logic [CODE_W-1:0] cand_q;
    logic [CODE_W-1:0] cand_d;
    logic [CODE_W-1:0] latched_q;
    logic [CODE_W-1:0] latched_d;
    logic              overflow_q;
    logic              overflow_d;

    logic              push_s;
    key_evt_t          push_evt_s;
    key_evt_t          head_evt_s;
    logic              fifo_empty_s;
    logic              fifo_drop_s;
    logic [LVL_W-1:0]  fifo_level_s;

    key_event_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W ($bits(key_evt_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (push_evt_s),
        .pop_i       (evt_ready),
        .head_data_o (head_evt_s),
        .level_o     (fifo_level_s),
        .empty_o     (fifo_empty_s),
        .drop_o      (fifo_drop_s)
    );

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            rpt_q       <= {RPT_W{1'b0}};
            rpt_first_q <= 1'b1;
            cand_q      <= {CODE_W{1'b0}};
            latched_q   <= {CODE_W{1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
            cand_q      <= cand_d;
            latched_q   <= latched_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state logic: debounce, lockout while held, repeat timing and event generation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rpt_d        = rpt_q;
        rpt_first_d  = rpt_first_q;
        cand_d       = cand_q;
        latched_d    = latched_q;
        push_s       = 1'b0;
        push_evt_s   = '{etype: EVT_PRESS, code: latched_q};
        rpt_target_s = rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST;

        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    state_d = ST_DB_PRESS;
                    cand_d  = key_code;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DB_PRESS: begin
                if (!key_valid) begin
                    state_d = ST_IDLE;
                end else if (key_code != cand_q) begin
                    cand_d = key_code;
                    cnt_d  = {CNT_W{1'b0}};
                end else if (cnt_q == DB_LAST) begin
                    state_d     = ST_HELD;
                    latched_d   = cand_q;
                    push_s      = 1'b1;
                    push_evt_s  = '{etype: EVT_PRESS, code: cand_q};
                    rpt_d       = {RPT_W{1'b0}};
                    rpt_first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                // The first repeat waits the long delay, later ones the short period.
                if (!key_valid) begin
                    state_d = ST_DB_REL;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (!repeat_en) begin
                    rpt_d       = {RPT_W{1'b0}};
                    rpt_first_d = 1'b1;
                end else if (rpt_q == rpt_target_s) begin
                    push_s      = 1'b1;
                    push_evt_s  = '{etype: EVT_REPEAT, code: latched_q};
                    rpt_d       = {RPT_W{1'b0}};
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
            end
            ST_DB_REL: begin
                if (key_valid) begin
                    state_d     = ST_HELD;
                    rpt_d       = {RPT_W{1'b0}};
                    rpt_first_d = 1'b1;
                end else if (cnt_q == DB_LAST) begin
                    state_d    = ST_IDLE;
                    push_s     = REL_PUSH;
                    push_evt_s = '{etype: EVT_RELEASE, code: latched_q};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fifo_drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Outputs; head fields read as zero while the queue is empty.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        evt_valid  = ~fifo_empty_s;
        fifo_level = fifo_level_s;
        overflow   = overflow_q;
        if (fifo_empty_s) begin
            evt_type = 2'd0;
            evt_code = {CODE_W{1'b0}};
        end else begin
            evt_type = head_evt_s.etype;
            evt_code = head_evt_s.code;
        end
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed vector table, hand-written overflow/reset sequences
// and randomized stimulus against a run-length based reference model.
module tb_key_event_queue;
    import key_event_pkg::*;

    localparam int CW    = 4;
    localparam int D     = 4;
    localparam int RD    = 10;
    localparam int RP    = 5;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          key_valid;
    logic [CW-1:0] key_code;
    logic          repeat_en;
    logic          evt_ready;
    logic          evt_valid;
    logic [1:0]    evt_type;
    logic [CW-1:0] evt_code;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic          overflow_clr;
    logic          busy;

    key_event_queue #(
        .CODE_W(CW), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .FIFO_DEPTH(DEPTH), .REL_EVT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .repeat_en(repeat_en), .evt_ready(evt_ready), .evt_valid(evt_valid),
        .evt_type(evt_type), .evt_code(evt_code), .fifo_level(fifo_level),
        .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [1:0]    t;
        logic [CW-1:0] c;
    } mevt_t;

    typedef struct {
        logic          kv;
        logic [CW-1:0] code;
        int            n;
        logic          e_valid;
        logic [1:0]    e_type;
        logic [CW-1:0] e_code;
        int            e_level;
        logic          e_busy;
    } vec_t;

    vec_t tbl [16];

    // Reference model state: run lengths of stable samples and a plain event queue.
    mevt_t         mq[$];
    bit            m_ovf;
    bit            m_pressed;
    int            m_run;
    int            m_zero;
    int            m_held;
    logic [CW-1:0] m_runcode;
    logic [CW-1:0] m_latched;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf     = 1'b0;
        m_pressed = 1'b0;
        m_run     = 0;
        m_zero    = 0;
        m_held    = 0;
        m_runcode = '0;
        m_latched = '0;
    endtask

    // A press needs D+1 identical valid samples; a release D+1 invalid samples.
    task automatic model_step(input logic kv, input logic [CW-1:0] code,
                              input logic ren, input logic rdy, input logic clr);
        bit    ev;
        mevt_t e;
        bit    drop;
        ev   = 1'b0;
        drop = 1'b0;
        e    = '0;
        if (!m_pressed) begin
            if (!kv) m_run = 0;
            else if (m_run > 0 && code == m_runcode) m_run++;
            else begin
                m_run     = 1;
                m_runcode = code;
            end
            if (m_run == D + 1) begin
                m_pressed = 1'b1;
                m_latched = code;
                m_run     = 0;
                m_zero    = 0;
                m_held    = 0;
                ev        = 1'b1;
                e.t       = 2'd0;
                e.c       = code;
            end
        end else if (!kv) begin
            m_zero++;
            if (m_zero == D + 1) begin
                m_pressed = 1'b0;
                m_zero    = 0;
                ev        = 1'b1;
                e.t       = 2'd2;
                e.c       = m_latched;
            end
        end else if (m_zero > 0) begin
            m_zero = 0;
            m_held = 0;
        end else if (!ren) begin
            m_held = 0;
        end else begin
            m_held++;
            if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0)) begin
                ev  = 1'b1;
                e.t = 2'd1;
                e.c = m_latched;
            end
        end
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (ev) begin
            if (mq.size() == DEPTH) drop = 1'b1;
            else mq.push_back(e);
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic compare_model();
        chk("evt_valid", evt_valid, mq.size() > 0);
        chk("fifo_level", fifo_level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, m_pressed || m_run > 0);
        if (mq.size() > 0) begin
            chk("evt_type", evt_type, mq[0].t);
            chk("evt_code", evt_code, mq[0].c);
        end
    endtask

    task automatic step(input logic kv, input logic [CW-1:0] code,
                        input logic ren, input logic rdy, input logic clr);
        key_valid    = kv;
        key_code     = code;
        repeat_en    = ren;
        evt_ready    = rdy;
        overflow_clr = clr;
        model_step(kv, code, ren, rdy, clr);
        @(posedge clk);
        #1;
        cyc++;
        compare_model();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, evt_valid, 0);
        chk({tag, "_type"}, evt_type, 0);
        chk({tag, "_code"}, evt_code, 0);
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_rows(input int first, input int last, input string tag);
        for (int r = first; r <= last; r++) begin
            for (int n = 0; n < tbl[r].n; n++) step(tbl[r].kv, tbl[r].code, 1'b0, 1'b1, 1'b0);
            chk($sformatf("%s_row%0d_valid", tag, r), evt_valid, tbl[r].e_valid);
            chk($sformatf("%s_row%0d_level", tag, r), fifo_level, tbl[r].e_level);
            chk($sformatf("%s_row%0d_busy", tag, r), busy, tbl[r].e_busy);
            if (tbl[r].e_valid) begin
                chk($sformatf("%s_row%0d_type", tag, r), evt_type, tbl[r].e_type);
                chk($sformatf("%s_row%0d_code", tag, r), evt_code, tbl[r].e_code);
            end
        end
    endtask

    initial begin
        int    rep_pos[$];
        mevt_t got[$];
        mevt_t cap;
        int    exp_t[6];

        // kv, code, cycles, exp valid, type, code, level, busy
        tbl[0]  = '{1'b1, 4'h7, 4,  1'b0, 2'd0, 4'h0, 0, 1'b1};
        tbl[1]  = '{1'b1, 4'h7, 1,  1'b1, 2'd0, 4'h7, 1, 1'b1};
        tbl[2]  = '{1'b1, 4'h7, 15, 1'b0, 2'd0, 4'h0, 0, 1'b1};
        tbl[3]  = '{1'b0, 4'h7, 4,  1'b0, 2'd0, 4'h0, 0, 1'b1};
        tbl[4]  = '{1'b0, 4'h7, 1,  1'b1, 2'd2, 4'h7, 1, 1'b0};
        tbl[5]  = '{1'b0, 4'h0, 5,  1'b0, 2'd0, 4'h0, 0, 1'b0};
        tbl[6]  = '{1'b1, 4'h3, 1,  1'b0, 2'd0, 4'h0, 0, 1'b1};
        tbl[7]  = '{1'b0, 4'h3, 1,  1'b0, 2'd0, 4'h0, 0, 1'b0};
        tbl[8]  = '{1'b1, 4'h3, 1,  1'b0, 2'd0, 4'h0, 0, 1'b1};
        tbl[9]  = '{1'b1, 4'h3, 2,  1'b0, 2'd0, 4'h0, 0, 1'b1};
        tbl[10] = '{1'b1, 4'h5, 4,  1'b0, 2'd0, 4'h0, 0, 1'b1};
        tbl[11] = '{1'b1, 4'h5, 1,  1'b1, 2'd0, 4'h5, 1, 1'b1};
        tbl[12] = '{1'b1, 4'h5, 3,  1'b0, 2'd0, 4'h0, 0, 1'b1};
        tbl[13] = '{1'b0, 4'h5, 4,  1'b0, 2'd0, 4'h0, 0, 1'b1};
        tbl[14] = '{1'b0, 4'h5, 1,  1'b1, 2'd2, 4'h5, 1, 1'b0};
        tbl[15] = '{1'b0, 4'h0, 2,  1'b0, 2'd0, 4'h0, 0, 1'b0};

        rst = 1'b1; key_valid = 1'b0; key_code = '0; repeat_en = 1'b0;
        evt_ready = 1'b1; overflow_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Clean press, then bounce with code change
        run_rows(0, 5, "s1");
        run_rows(6, 15, "s2");

        // Auto-repeat enabled: REPEAT at HELD cycles 10,15,20,25,30
        repeat (5) step(1'b1, 4'h9, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            step(1'b1, 4'h9, 1'b1, 1'b1, 1'b0);
            if (evt_valid && evt_type == EVT_REPEAT) rep_pos.push_back(k);
        end
        chk("s3_rep_count", rep_pos.size(), 5);
        for (int i = 0; i < rep_pos.size() && i < 5; i++) chk("s3_rep_pos", rep_pos[i], 10 + 5 * i);
        repeat (7) step(1'b0, 4'h9, 1'b1, 1'b1, 1'b0);
        rep_pos.delete();
        repeat (5) step(1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            step(1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
            if (evt_valid && evt_type == EVT_REPEAT) rep_pos.push_back(k);
        end
        chk("s3_norep_count", rep_pos.size(), 0);
        repeat (7) step(1'b0, 4'h9, 1'b0, 1'b1, 1'b0);

        // Overflow with consumer stalled, then clear
        repeat (5) step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
        repeat (30) step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
        chk("s4_level", fifo_level, 4);
        chk("s4_ovf", overflow, 1);
        step(1'b1, 4'hA, 1'b1, 1'b0, 1'b1);
        chk("s4_ovf_clr", overflow, 0);
        repeat (3) step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);

        // Full queue with push and pop in the same cycle, then drain
        cap.t = evt_type; cap.c = evt_code;
        if (evt_valid) got.push_back(cap);
        step(1'b1, 4'hA, 1'b1, 1'b1, 1'b0);
        chk("s5_level", fifo_level, 4);
        chk("s5_ovf", overflow, 0);
        chk("s5_head_type", evt_type, EVT_REPEAT);
        for (int i = 0; i < 6; i++) begin
            cap.t = evt_type; cap.c = evt_code;
            if (evt_valid) got.push_back(cap);
            step(1'b0, 4'hA, 1'b1, 1'b1, 1'b0);
        end
        exp_t = '{0, 1, 1, 1, 1, 2};
        chk("s5_drain_count", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++) begin
            chk("s5_drain_type", got[i].t, exp_t[i]);
            chk("s5_drain_code", got[i].c, 10);
        end

        // Async reset mid-debounce with two entries queued
        repeat (8) step(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        chk("s6_pre_level", fifo_level, 2);
        chk("s6_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_zero("s6_async");
        model_reset();
        key_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        run_rows(0, 5, "s6_replay");

        // Randomized stimulus against the model
        for (int seg = 0; seg < 400; seg++) begin
            logic          kv;
            logic [CW-1:0] code;
            logic          ren;
            int            len;
            int            rdy_pct;
            kv      = ($urandom_range(0, 3) != 0);
            code    = CW'($urandom_range(0, 3));
            ren     = 1'($urandom_range(0, 1));
            len     = $urandom_range(1, 12);
            rdy_pct = $urandom_range(10, 100);
            for (int i = 0; i < len; i++) begin
                step(kv, code, ren, ($urandom_range(1, 100) <= rdy_pct),
                     ($urandom_range(0, 19) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
Parametrised successor to the keypad one-shot stage. It debounces a decoded keypad code and generates typed key events: PRESS, optional auto-repeat, and optional RELEASE. Events are buffered in a small FIFO with a valid/ready interface toward the display/controller logic. It sits between the keypad scanner (key_valid/key_code) and the consumer, so slow consumers do not lose keystrokes.

Parameters:
CODE_W, 4, key code width in bits
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or release (>=2)
REPEAT_DELAY, 24000000, cycles held in HELD before the first REPEAT event
REPEAT_PERIOD, 6000000, cycles between subsequent REPEAT events
FIFO_DEPTH, 4, event queue depth (power of 2, >=2)
REL_EVT_EN, 1, 1 = push RELEASE events; 0 = suppress them

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
key_valid  in  1  any key detected by scanner
key_code  in  CODE_W  code of detected key
repeat_en  in  1  enables auto-repeat (sampled each cycle)
evt_ready  in  1  consumer accepts head event
evt_valid  out  1  FIFO non-empty
evt_type  out  2  head event type: 0 PRESS, 1 REPEAT, 2 RELEASE
evt_code  out  CODE_W  head event key code
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: an event was dropped
overflow_clr  in  1  clears overflow
busy  out  1  FSM not IDLE

Behaviour:
- Reset (async assert, sync release): FSM IDLE, counters 0, FIFO empty, evt_valid=0, evt_type=0, evt_code=0, fifo_level=0, overflow=0, busy=0.
- FSM states: IDLE, DB_PRESS, HELD, DB_REL.
- IDLE: key_valid=1 -> DB_PRESS; capture cand_code=key_code; cnt=0.
- DB_PRESS, each cycle:
  - key_valid=0 -> IDLE.
  - key_code!=cand_code -> stay; cand_code=key_code; cnt=0 (restart).
  - cnt==DEBOUNCE_CYCLES-1 -> HELD; latched_code=cand_code; push PRESS; rpt_cnt=0.
  - Otherwise cnt++.
- Press latency: with key_valid held steady from the first sampling edge E0, the PRESS is written at edge E_D (D=DEBOUNCE_CYCLES). evt_valid rises after E_D when the FIFO was empty.
- HELD:
  - key_valid=0 -> DB_REL; cnt=0.
  - Code changes while key_valid=1 are ignored (lockout until full release).
  - If repeat_en=1: rpt_cnt++ each cycle. At rpt_cnt==REPEAT_DELAY-1, push REPEAT(latched_code). Thereafter push REPEAT every REPEAT_PERIOD cycles.
  - If repeat_en=0: rpt_cnt held at 0, no REPEAT events.
- DB_REL:
  - key_valid=1 -> HELD; rpt_cnt=0, so the repeat delay restarts.
  - cnt==DEBOUNCE_CYCLES-1 with key_valid=0 -> IDLE; push RELEASE(latched_code) if REL_EVT_EN.
  - Otherwise cnt++.
- At most one push per cycle.
- FIFO, registered, first-word-fall-through:
  - evt_type/evt_code show the head entry whenever evt_valid=1.
  - Pop on evt_valid&evt_ready.
  - Push when full with no pop in the same cycle: event dropped, overflow set next cycle.
  - Push and pop in the same cycle when full: both happen, level unchanged.
  - Push and pop in the same cycle when empty: the pop does not occur (evt_valid was 0); the pushed entry appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow_clr and a drop in the same cycle: overflow stays 1 (set wins).
- Counter widths: $clog2 of the maximum count + 1. No count saturates past its terminal value.
- Reset mid-operation: FIFO contents discarded; no event emitted.

Decomposition:
- Package key_event_pkg: evt_type_t enum (EVT_PRESS=2'd0, EVT_REPEAT=2'd1, EVT_RELEASE=2'd2), state_t enum, event struct {evt_type_t type; code}. The code width is passed as a parameter.
- Sub-module key_event_fifo: parametrised depth/width sync FIFO with level, full, empty, and drop indication.
- FSM and counters stay in the top module.

Test Plan:
Test parameters for all scenarios: D=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, FIFO_DEPTH=4, REL_EVT_EN=1, evt_ready=1 unless stated.
1. Clean press: key_valid=1, key_code=4'h7 held 20 cycles, then released 10 cycles -> one PRESS 7 (evt_valid after edge 4), then one RELEASE 7 four cycles after release; no other events.
2. Bounce and code change: key_valid toggles 1,0,1 in 3 cycles, then code 3 for 2 cycles, then code 5 held -> single PRESS 5; press latency counted from the switch to 5.
3. Auto-repeat: repeat_en=1, key 9 held 30 cycles after PRESS -> REPEAT 9 at HELD cycles 10, 15, 20, 25, 30; with repeat_en=0, none.
4. Overflow: evt_ready=0, repeat_en=1, hold until 6 events are generated -> fifo_level=4, overflow=1, dropped events absent. Pulse overflow_clr -> overflow=0. Drain yields the first 4 events in order.
5. Full with simultaneous push/pop: level=4, evt_ready=1 on the same cycle a REPEAT is pushed -> level stays 4; order preserved.
6. Async reset mid-DB_PRESS and with FIFO holding 2 entries -> all outputs zero immediately, with no clock edge needed; after release, a fresh press behaves as scenario 1.
